axis_elastic_buffer: RTL
========================

Name: axis_elastic_buffer

Overview:
Parametrised successor to the single-entry skid buffer. It is a DEPTH-entry elastic buffer on a generic AXI-Stream-style valid/ready channel, with a sideband last bit, occupancy output and synchronous flush. It sits between pipeline stages to break both timing paths:
- in_ready is a pure register, with no path from out_ready.
- out_valid and out_data come from flops, with no path from in_valid or in_data.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of storage entries; power of two, >=2
LVL_W, $clog2(DEPTH+1), width of the level output (localparam, not overridable)

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stored beats
in_data  input  DATA_WIDTH  upstream payload
in_last  input  1  upstream end-of-packet marker
in_valid  input  1  upstream beat valid
in_ready  output  1  buffer can accept a beat (registered)
out_data  output  DATA_WIDTH  downstream payload
out_last  output  1  downstream end-of-packet marker
out_valid  output  1  downstream beat valid (registered)
out_ready  input  1  downstream accepts beat
level  output  LVL_W  number of beats currently stored

Behaviour:
- Reset (resetn low, asynchronous):
  - count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, in_ready=0, level=0.
  - out_data and out_last are don't-care; they are reset to 0 regardless.
- First rising edge after resetn deasserts: in_ready becomes 1.
- Transfer definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage:
  - Flop array mem[DEPTH] of {last, data}.
  - On push, write mem[wr_ptr] and advance wr_ptr.
  - On pop, advance rd_ptr.
  - Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Outputs:
  - out_data and out_last = mem[rd_ptr]; this mux is fed only by flops.
  - out_valid is a register: out_valid_next = (count_next != 0).
  - in_ready is a register: in_ready_next = (count_next != DEPTH).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Latency: a beat pushed at edge k is presented with out_valid=1 after edge k. There is no same-cycle passthrough; minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained whenever 0 < count < DEPTH.
- Full (count==DEPTH):
  - in_ready=0, so no push.
  - A pop in that cycle makes in_ready=1 on the next cycle (one-cycle ready recovery, matching the skid behaviour).
- Empty (count==0): out_valid=0, so no pop.
  - A push in that cycle makes out_valid=1 on the next cycle.
- Flush:
  - Priority over push and pop in the same cycle; a beat offered during flush is dropped even if in_ready was 1.
  - Next cycle: count=0, pointers=0, out_valid=0, in_ready=1.
- Mid-operation reset: all state is discarded immediately; outputs take their reset values asynchronously.
- AXI-Stream obligations:
  - While out_valid=1 and out_ready=0, out_valid, out_data and out_last hold stable.
  - out_valid never drops without a pop, except on flush or reset.
  - Upstream may drop in_valid freely; the block places no stability requirement on upstream beyond the stream protocol.
- Ordering: beats exit in exact FIFO order, with in_last carried alongside its data.
- level equals count (registered).

Decomposition:
- No shared package is needed; LVL_W and the pointer width are module-local localparams.
- Single module; no sub-module is warranted.
- Formal harness axis_elastic_buffer_tb_formal uses the existing AXI-Stream master monitor on the out_* side and slave monitor on the in_* side, with tstrb and tkeep tied to all-ones. It asserts:
  - level <= DEPTH.
  - in_ready == (level != DEPTH).
  - out_valid == (level != 0).
  - Data ordering, using a tracked-beat (any-constant index) check.

Test Plan:
- Reset with DEPTH=4, DATA_WIDTH=8; hold resetn low 3 cycles -> in_ready=0, out_valid=0, level=0. First edge after release -> in_ready=1.
- Push 0x11,0x22,0x33,0x44 back-to-back with out_ready=0 -> level 1,2,3,4; in_ready=0 after the 4th push; out_data=0x11 held stable with out_valid=1.
- From full, assert out_ready=1 and in_valid=1 with 0x55 -> cycle 1 pops 0x11 and in_ready=0; cycle 2 in_ready=1. Output order is 0x22,0x33,0x44,0x55.
- Streaming with in_valid=out_ready=1 for 16 cycles, data 0..15 and in_last on 7 and 15 -> after the 1-cycle fill, 1 beat/cycle. out_last appears only with data 7 and 15; level stays 1.
- With level=3, assert flush together with in_valid=1 (0xAA) and out_ready=1 -> next cycle level=0, out_valid=0, in_ready=1; 0xAA never appears at the output.
- Pulse resetn low asynchronously mid-stream at level=2 -> out_valid falls before the next clk edge. After release, the old data is never output.

Source files
------------

// File: rtl/axis_elastic_buffer.sv
// axis_elastic_buffer: DEPTH-entry valid/ready elastic buffer with sideband last, level and flush.
// Both handshake outputs are flops so neither timing path crosses the block combinationally.
module axis_elastic_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LVL_W-1:0]      level
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] count, count_next;
    logic push, pop;
    // Flush suppresses both handshakes so an offered beat is dropped.
    assign push = in_valid & in_ready & ~flush;
    assign pop = out_valid & out_ready & ~flush;
    assign {out_last, out_data} = mem[rd_ptr];
    assign level = count;
    always_comb begin
        count_next = flush ? '0 :
                     (push && !pop) ? count + 1'b1 :
                     (pop && !push) ? count - 1'b1 : count;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            out_valid <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (push) mem[wr_ptr] <= {in_last, in_data};
            rd_ptr <= flush ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= flush ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            count <= count_next;
            out_valid <= count_next != '0;
            in_ready <= count_next != LVL_W'(DEPTH);
        end
    end
endmodule
